mic1_sequencer: RTL and testbench
=================================

# mic1_sequencer

Microsequencer for the MIC-1 datapath. It holds MPC and MIR and fetches 36-bit microinstructions from a synchronous control store. It drives the 8-bit ALU select word, the C-bus write enables, the B-bus source and the memory strobes. It consumes the ALU's N and Z flags and the MBR byte to compute the next microaddress, and so closes the loop with the ALU.

## Interface
Parameters:
- RESET_ADDR, 9'h000, microaddress loaded into MPC on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- alu_n  input  1  ALU N flag (result bit 31), combinational from the ALU.
- alu_z  input  1  ALU Z flag (result == 0), combinational from the ALU.
- mbr  input  8  MBR byte for JMPC dispatch.
- mem_wait  input  1  memory not ready; stalls completion of a READ/WRITE/FETCH microinstruction.
- alu_select  output  8  MIR[23:16]: {SLL8, SRA1, F0, F1, ENA, ENB, INVA, INC}.
- c_en  output  9  C-bus register write enables: H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR.
- b_sel  output  4  B-bus source code from MIR[3:0].
- mem_write, mem_read, mem_fetch  output  1 each  memory strobes.
- mpc  output  9  current MPC, for debug.

## Operation
- MIR layout: [35:27] NEXT_ADDRESS, [26:24] JAM = {JMPC, JAMN, JAMZ}, [23:16] ALU, [15:7] C, [6:4] MEM = {WRITE, READ, FETCH}, [3:0] B.
- States:
  - RST: entered on reset.
  - FETCH: control store is addressed by MPC; MIR loads at the edge that ends the state.
  - EXEC: MIR drives the datapath.
  - WAIT: stalled on memory.
- Transitions:
  - RST→FETCH after one cycle.
  - FETCH→EXEC always.
  - EXEC→FETCH if no MEM bit is set or mem_wait=0.
  - EXEC→WAIT if any MEM bit is set and mem_wait=1.
  - WAIT stays in WAIT while mem_wait=1; WAIT→FETCH when mem_wait=0.
- Flags: N and Z are registered at the edge that leaves EXEC or WAIT toward FETCH. They are never registered on the edge into WAIT.
- Next address is computed on the same edge as the flag capture:
  - mpc[8] = NEXT[8] | (JAMN & N) | (JAMZ & Z).
  - mpc[7:0] = NEXT[7:0] | (JMPC ? mbr : 8'h00).
  - The flag terms use the live alu_n/alu_z, not the prior registered copy. The combination is a bitwise OR, with no carry.
- Output gating:
  - alu_select and b_sel follow MIR in every state.
  - c_en is MIR C-field only in the final datapath cycle: EXEC with no stall, or WAIT with mem_wait=0. Otherwise c_en is 0, so registers are written exactly once.
  - mem_* strobes are MIR MEM-field during EXEC and WAIT, and 0 otherwise.
- Microaddress arithmetic is 9-bit. The control store depth is 512, so there is no wrap logic.
- Reset mid-operation, including during WAIT, aborts immediately: all strobes drop and MPC reloads RESET_ADDR.

## Timing
- Reset values:
  - state=RST, mpc=RESET_ADDR, MIR=0.
  - alu_select=8'h00, c_en=0, b_sel=0, mem_*=0.
  - Registered N=0, Z=0.
- Unstalled microinstruction: 2 cycles (FETCH, EXEC). Each WAIT cycle adds 1.
- Control store read latency is 1 cycle. Its address is MPC; the data is registered into MIR.
- mem_wait is sampled only in EXEC and WAIT, and ignored in FETCH and RST.
- If the ALU flags change during WAIT, the value at the exit edge wins.

## Configuration
- MIC1_SEQ_BREAKPOINT_EN: adds these ports:
  - bkpt_addr input 9.
  - bkpt_en input 1.
  - resume input 1.
  - halted output 1.
- With the macro defined, a HALT state exists. When entering FETCH with bkpt_en=1 and mpc==bkpt_addr, the block goes to HALT instead.
  - In HALT, halted=1 and all strobes and c_en are 0.
  - A resume=1 sample exits HALT to FETCH at the same MPC, with the breakpoint suppressed for that one fetch.
  - halted resets to 0.
- Without the macro: no extra ports and no HALT state. Behaviour is identical to the enabled build with bkpt_en tied 0.

## Structure
- Shared package mic1_pkg holds:
  - MIR field bit-position constants.
  - The ALU select encodings used by the ALU, e.g. 8'b00111100 for A+B and 8'b00111111 for B−A.
  - The C-enable bit order and the B-source codes.
  - The state enum.
- One sub-module: mic1_control_store, a 512×36 synchronous ROM initialised from a hex file, with ports clk, addr[8:0] and data[35:0]. The sequencer owns MIR and MPC.

## Test plan
- Reset then release; ROM[0]=NEXT 9'h005, ALU 8'b00011000, C=H → mpc 0→5 after 3 cycles; c_en=H asserted exactly in the EXEC cycle; alu_select=8'h18.
- JAMZ with NEXT=9'h010, alu_z=1 at EXEC → next mpc=9'h110; repeat with alu_z=0 → 9'h010.
- JAMN with NEXT=9'h020, alu_n=1 → 9'h120; JAMN and JAMZ with both flags set → 9'h120.
- JMPC with NEXT=9'h000, mbr=8'h60 → mpc=9'h060; with NEXT=9'h100 → 9'h160.
- READ microinstruction with mem_wait high for 3 cycles → mem_read held for 4 cycles; c_en pulses once, in the last cycle; the next FETCH follows.
- Assert reset during WAIT → all strobes 0 in the same cycle; mpc=RESET_ADDR. With MIC1_SEQ_BREAKPOINT_EN and bkpt_addr=9'h005 → halted=1 at mpc 5; resume → proceeds.

Source files
------------

// File: rtl/mic1_pkg.sv
// Shared MIC-1 definitions: MIR layout, ALU select words, C-enable order, B codes, sequencer states.
// MIC1_SEQ_BREAKPOINT_EN adds the HALT state to the enum.
package mic1_pkg;

  localparam int MIR_W    = 36;
  localparam int CS_DEPTH = 512;

  localparam int NEXT_LSB = 27;
  localparam int JAM_LSB  = 24;
  localparam int ALU_LSB  = 16;
  localparam int C_LSB    = 7;
  localparam int MEM_LSB  = 4;
  localparam int B_LSB    = 0;

  localparam logic [2:0] JAM_JMPC = 3'b100;
  localparam logic [2:0] JAM_JAMN = 3'b010;
  localparam logic [2:0] JAM_JAMZ = 3'b001;

  localparam logic [2:0] MEM_WRITE = 3'b100;
  localparam logic [2:0] MEM_READ  = 3'b010;
  localparam logic [2:0] MEM_FETCH = 3'b001;

  // {SLL8, SRA1, F0, F1, ENA, ENB, INVA, INC}
  localparam logic [7:0] ALU_A         = 8'b00011000;
  localparam logic [7:0] ALU_B         = 8'b00010100;
  localparam logic [7:0] ALU_A_PLUS_B  = 8'b00111100;
  localparam logic [7:0] ALU_B_MINUS_A = 8'b00111111;
  localparam logic [7:0] ALU_ZERO      = 8'b00010000;
  localparam logic [7:0] ALU_ONE       = 8'b00110001;

  localparam int CEN_H   = 8;
  localparam int CEN_OPC = 7;
  localparam int CEN_TOS = 6;
  localparam int CEN_CPP = 5;
  localparam int CEN_LV  = 4;
  localparam int CEN_SP  = 3;
  localparam int CEN_PC  = 2;
  localparam int CEN_MDR = 1;
  localparam int CEN_MAR = 0;

  localparam logic [3:0] B_MDR  = 4'd0;
  localparam logic [3:0] B_PC   = 4'd1;
  localparam logic [3:0] B_MBR  = 4'd2;
  localparam logic [3:0] B_MBRU = 4'd3;
  localparam logic [3:0] B_SP   = 4'd4;
  localparam logic [3:0] B_LV   = 4'd5;
  localparam logic [3:0] B_CPP  = 4'd6;
  localparam logic [3:0] B_TOS  = 4'd7;
  localparam logic [3:0] B_OPC  = 4'd8;

  typedef struct packed {
    logic [8:0] next_addr;
    logic       jmpc;
    logic       jamn;
    logic       jamz;
    logic [7:0] alu;
    logic [8:0] c;
    logic       mem_write;
    logic       mem_read;
    logic       mem_fetch;
    logic [3:0] b;
  } mir_t;

  typedef logic [CS_DEPTH-1:0][MIR_W-1:0] cs_image_t;

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_EXEC,
`ifdef MIC1_SEQ_BREAKPOINT_EN
    ST_WAIT,
    ST_HALT
`else
    ST_WAIT
`endif
  } state_t;

endpackage

// File: rtl/mic1_control_store.sv
// 512x36 synchronous microcode ROM; image comes in as a parameter built from the microcode hex.
// One-cycle read latency, no backpressure.
module mic1_control_store
  import mic1_pkg::*;
#(
  parameter cs_image_t INIT = '0
) (
  input  logic        clk,
  input  logic [8:0]  addr,
  output logic [35:0] data
);

  always_ff @(posedge clk) begin
    data <= INIT[addr];
  end

endmodule

// File: rtl/mic1_sequencer.sv
// MIC-1 microsequencer: owns MPC/MIR, 2 cycles per microinstruction plus one per memory stall cycle.
// mem_wait holds EXEC/WAIT; MIC1_SEQ_BREAKPOINT_EN adds bkpt_addr/bkpt_en/resume/halted and a HALT state.
module mic1_sequencer
  import mic1_pkg::*;
#(
  parameter logic [8:0] RESET_ADDR = 9'h000,
  parameter cs_image_t  CS_INIT    = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic [7:0] mbr,
  input  logic       mem_wait,
`ifdef MIC1_SEQ_BREAKPOINT_EN
  input  logic [8:0] bkpt_addr,
  input  logic       bkpt_en,
  input  logic       resume,
  output logic       halted,
`endif
  output logic [7:0] alu_select,
  output logic [8:0] c_en,
  output logic [3:0] b_sel,
  output logic       mem_write,
  output logic       mem_read,
  output logic       mem_fetch,
  output logic [8:0] mpc
);

  state_t      state, state_d;
  mir_t        mir;
  logic [35:0] cs_data;
  logic [8:0]  mpc_d;
  logic        any_mem;
  logic        last;
  logic        n_q, z_q;
  logic        unused_flags;

  // Addressed with the next MPC so cs_data always reflects the current MPC.
  mic1_control_store #(.INIT(CS_INIT)) u_cs (
    .clk  (clk),
    .addr (mpc_d),
    .data (cs_data)
  );

  assign any_mem    = mir.mem_write | mir.mem_read | mir.mem_fetch;
  assign alu_select = mir.alu;
  assign b_sel      = mir.b;
  assign unused_flags = n_q ^ z_q;

  always_comb begin
    state_d   = state;
    mpc_d     = mpc;
    last      = 1'b0;
    c_en      = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_fetch = 1'b0;
`ifdef MIC1_SEQ_BREAKPOINT_EN
    halted    = 1'b0;
`endif
    case (state)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        {mem_write, mem_read, mem_fetch} = {mir.mem_write, mir.mem_read, mir.mem_fetch};
        if (!any_mem || !mem_wait) last = 1'b1;
        else                       state_d = ST_WAIT;
      end
      ST_WAIT: begin
        {mem_write, mem_read, mem_fetch} = {mir.mem_write, mir.mem_read, mir.mem_fetch};
        if (!mem_wait) last = 1'b1;
      end
`ifdef MIC1_SEQ_BREAKPOINT_EN
      ST_HALT: begin
        halted = 1'b1;
        if (resume) state_d = ST_FETCH;
      end
`endif
      default: state_d = ST_RST;
    endcase

    // Flag jams OR into NEXT_ADDRESS using the live ALU flags; no carry.
    if (last) begin
      state_d = ST_FETCH;
      c_en    = mir.c;
      mpc_d   = {mir.next_addr[8] | (mir.jamn & alu_n) | (mir.jamz & alu_z),
                 mir.next_addr[7:0] | (mir.jmpc ? mbr : 8'h00)};
    end

`ifdef MIC1_SEQ_BREAKPOINT_EN
    // Resume goes HALT->FETCH directly, so the breakpoint is skipped for that fetch.
    if ((state == ST_RST || last) && bkpt_en && (mpc_d == bkpt_addr)) state_d = ST_HALT;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RST;
      mpc   <= RESET_ADDR;
      mir   <= '0;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      state <= state_d;
      mpc   <= mpc_d;
      if (state == ST_FETCH) mir <= mir_t'(cs_data);
      if (last) begin
        n_q <= alu_n;
        z_q <= alu_z;
      end
    end
  end

endmodule

// File: tb/tb_mic1_sequencer.sv
// Directed bench for mic1_sequencer: microcode image built in-bench, expected MPC/strobes hand-computed.
module tb_mic1_sequencer;
  import mic1_pkg::*;

  function automatic logic [35:0] uw(input logic [8:0] nxt, input logic [2:0] jam,
                                     input logic [7:0] alu, input logic [8:0] c,
                                     input logic [2:0] mem, input logic [3:0] b);
    return (36'(nxt) << NEXT_LSB) | (36'(jam) << JAM_LSB) | (36'(alu) << ALU_LSB) |
           (36'(c) << C_LSB) | (36'(mem) << MEM_LSB) | (36'(b) << B_LSB);
  endfunction

  function automatic cs_image_t build_rom();
    cs_image_t r = '0;
    r[9'h000] = uw(9'h005, 3'b000, ALU_A, 9'd1 << CEN_H, 3'b000, B_PC);
    r[9'h005] = uw(9'h010, JAM_JAMZ, ALU_B_MINUS_A, 9'd0, 3'b000, B_TOS);
    r[9'h110] = uw(9'h010, JAM_JAMZ, ALU_A_PLUS_B, 9'd0, 3'b000, B_OPC);
    r[9'h010] = uw(9'h020, JAM_JAMN, ALU_B, 9'd0, 3'b000, B_SP);
    r[9'h120] = uw(9'h020, JAM_JAMN | JAM_JAMZ, ALU_ZERO, 9'd0, 3'b000, B_CPP);
    r[9'h020] = uw(9'h000, JAM_JMPC, ALU_ONE, 9'd0, 3'b000, B_MBR);
    r[9'h060] = uw(9'h100, JAM_JMPC, ALU_B, 9'd0, 3'b000, B_MBR);
    r[9'h160] = uw(9'h030, 3'b000, ALU_B, 9'd1 << CEN_MDR, MEM_READ, B_MBRU);
    r[9'h030] = uw(9'h000, 3'b000, ALU_A_PLUS_B, 9'd1 << CEN_TOS, MEM_READ, B_LV);
    return r;
  endfunction

  localparam cs_image_t ROM = build_rom();

  logic       clk = 1'b0;
  logic       reset, alu_n, alu_z, mem_wait;
  logic [7:0] mbr;
  logic [7:0] alu_select;
  logic [8:0] c_en, mpc;
  logic [3:0] b_sel;
  logic       mem_write, mem_read, mem_fetch;
`ifdef MIC1_SEQ_BREAKPOINT_EN
  logic [8:0] bkpt_addr;
  logic       bkpt_en, resume, halted;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mic1_sequencer #(.RESET_ADDR(9'h000), .CS_INIT(ROM)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .mbr        (mbr),
    .mem_wait   (mem_wait),
`ifdef MIC1_SEQ_BREAKPOINT_EN
    .bkpt_addr  (bkpt_addr),
    .bkpt_en    (bkpt_en),
    .resume     (resume),
    .halted     (halted),
`endif
    .alu_select (alu_select),
    .c_en       (c_en),
    .b_sel      (b_sel),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_fetch  (mem_fetch),
    .mpc        (mpc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called in a FETCH cycle: drive flags/mbr for the EXEC that follows, then check the next MPC.
  task automatic jump(input string tag, input logic n, input logic z,
                      input logic [7:0] m, input logic [8:0] exp);
    alu_n = n;
    alu_z = z;
    mbr   = m;
    step();
    step();
    check(tag, 32'(mpc), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; alu_n = 1'b0; alu_z = 1'b0; mbr = 8'h00; mem_wait = 1'b0;
`ifdef MIC1_SEQ_BREAKPOINT_EN
    bkpt_addr = 9'h000; bkpt_en = 1'b0; resume = 1'b0;
`endif
    step();
    step();
    check("rst_mpc", 32'(mpc), 32'h000);
    check("rst_alu", 32'(alu_select), 32'h00);
    check("rst_cen", 32'(c_en), 32'h000);
    check("rst_bsel", 32'(b_sel), 32'h0);
    check("rst_mem", 32'({mem_write, mem_read, mem_fetch}), 32'h0);
`ifdef MIC1_SEQ_BREAKPOINT_EN
    check("rst_halted", 32'(halted), 32'h0);
`endif

    reset = 1'b0;
    step();
    check("fetch0_cen", 32'(c_en), 32'h000);
    check("fetch0_mpc", 32'(mpc), 32'h000);
    step();
    check("exec0_alu", 32'(alu_select), 32'h18);
    check("exec0_cen", 32'(c_en), 32'h100);
    check("exec0_bsel", 32'(b_sel), 32'(B_PC));
    step();
    check("next_mpc5", 32'(mpc), 32'h005);
    check("fetch5_cen", 32'(c_en), 32'h000);

    jump("jamz_set",   1'b0, 1'b1, 8'h00, 9'h110);
    jump("jamz_clr",   1'b0, 1'b0, 8'h00, 9'h010);
    jump("jamn_set",   1'b1, 1'b0, 8'h00, 9'h120);
    jump("jamnz_both", 1'b1, 1'b1, 8'h00, 9'h120);
    jump("jamnz_none", 1'b0, 1'b0, 8'h00, 9'h020);
    jump("jmpc_lo",    1'b0, 1'b0, 8'h60, 9'h060);
    jump("jmpc_hi",    1'b0, 1'b1, 8'h60, 9'h160);

    // READ at 0x160 with mem_wait high across EXEC and two WAIT cycles.
    mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_read%0d", i), 32'({mem_write, mem_read, mem_fetch}), 32'(MEM_READ));
      check($sformatf("stall_cen%0d", i), 32'(c_en), 32'h000);
    end
    step();
    mem_wait = 1'b0;
    #1;
    check("wait_last_read", 32'({mem_write, mem_read, mem_fetch}), 32'(MEM_READ));
    check("wait_last_cen", 32'(c_en), 32'h002);
    check("wait_last_bsel", 32'(b_sel), 32'(B_MBRU));
    step();
    check("post_wait_mem", 32'({mem_write, mem_read, mem_fetch}), 32'h0);
    check("post_wait_cen", 32'(c_en), 32'h000);
    check("post_wait_mpc", 32'(mpc), 32'h030);

    // Reset during WAIT at 0x030.
    mem_wait = 1'b1;
    step();
    step();
    check("wait2_read", 32'({mem_write, mem_read, mem_fetch}), 32'(MEM_READ));
    reset = 1'b1;
    #1;
    check("abort_mem", 32'({mem_write, mem_read, mem_fetch}), 32'h0);
    check("abort_cen", 32'(c_en), 32'h000);
    check("abort_mpc", 32'(mpc), 32'h000);
    check("abort_alu", 32'(alu_select), 32'h00);
    step();
    reset = 1'b0;
    mem_wait = 1'b0;
    step();
    step();
    step();
    check("restart_mpc", 32'(mpc), 32'h005);

`ifdef MIC1_SEQ_BREAKPOINT_EN
    reset = 1'b1;
    bkpt_addr = 9'h005;
    bkpt_en = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    step();
    check("bkpt_halted", 32'(halted), 32'h1);
    check("bkpt_mpc", 32'(mpc), 32'h005);
    check("bkpt_cen", 32'(c_en), 32'h000);
    check("bkpt_mem", 32'({mem_write, mem_read, mem_fetch}), 32'h0);
    step();
    check("bkpt_hold", 32'(halted), 32'h1);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume_halted", 32'(halted), 32'h0);
    check("resume_mpc", 32'(mpc), 32'h005);
    jump("resume_run", 1'b0, 1'b0, 8'h00, 9'h010);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
